// File: rtl/tile_spawn_scheduler.sv
// Tile spawn scheduler: paces TILE_COUNT spawns, one every INTERVAL ticks, lane drawn from rnd.
// Optional macro SPAWN_NO_REPEAT_EN bumps a lane that repeats the last transferred lane.
module tile_spawn_scheduler #(
  parameter int INTERVAL   = 8,
  parameter int TILE_COUNT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  input  logic [2:0] rnd,
  output logic       rnd_next,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [1:0] spawn_lane,
  output logic [7:0] spawn_idx,
  output logic       busy,
  output logic       done
);

  // state    | meaning
  // ST_IDLE  | waiting for start
  // ST_WAIT  | counting unpaused ticks down to the next spawn
  // ST_DRAW  | one cycle: capture lane from rnd, advance the generator
  // ST_OFFER | spawn offered until the consumer accepts it
  // ST_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DRAW, ST_OFFER, ST_DONE} state_t;

  localparam logic [7:0] INTERVAL_C = 8'(INTERVAL);
  localparam logic [7:0] LAST_IDX   = 8'(TILE_COUNT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] drawn_lane;
  logic       unused_rnd;

  assign unused_rnd = rnd[2];

`ifdef SPAWN_NO_REPEAT_EN
  logic [1:0] last_lane_q, last_lane_d;
  logic       last_valid_q, last_valid_d;

  always_comb begin
    drawn_lane = rnd[1:0];
    if (last_valid_q && (rnd[1:0] == last_lane_q)) begin
      drawn_lane = rnd[1:0] + 2'd1;
    end
  end
`else
  assign drawn_lane = rnd[1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
`ifdef SPAWN_NO_REPEAT_EN
    last_lane_d  = last_lane_q;
    last_valid_d = last_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = INTERVAL_C;
          idx_d   = 8'd0;
`ifdef SPAWN_NO_REPEAT_EN
          last_valid_d = 1'b0;
`endif
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tick && !pause) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        lane_d  = drawn_lane;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (spawn_ready) begin
`ifdef SPAWN_NO_REPEAT_EN
          last_lane_d  = lane_q;
          last_valid_d = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            cnt_d   = INTERVAL_C;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
    end
  end

`ifdef SPAWN_NO_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_lane_q  <= 2'd0;
      last_valid_q <= 1'b0;
    end else begin
      last_lane_q  <= last_lane_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  // Outputs decode straight from state so reset clears them asynchronously.
  assign rnd_next    = (state_q == ST_DRAW);
  assign spawn_valid = (state_q == ST_OFFER);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign spawn_lane  = lane_q;
  assign spawn_idx   = idx_q;

endmodule

// File: tb/tb_tile_spawn_scheduler.sv
// Directed bench for tile_spawn_scheduler with INTERVAL=4, TILE_COUNT=3.
module tb_tile_spawn_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       tick;
  logic [2:0] rnd;
  logic       rnd_next;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_lane;
  logic [7:0] spawn_idx;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;
  int rnd_next_cnt = 0;
  int done_cnt = 0;

  tile_spawn_scheduler #(.INTERVAL(4), .TILE_COUNT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .tick(tick),
    .rnd(rnd), .rnd_next(rnd_next), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_lane(spawn_lane), .spawn_idx(spawn_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rnd_next) rnd_next_cnt <= rnd_next_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_ticks(input int n, input logic p);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      pause = p;
      @(negedge clk);
      tick = 1'b0;
    end
    pause = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({spawn_valid, busy, done, rnd_next} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got valid/busy/done/rnd_next=%b want 0000",
               {spawn_valid, busy, done, rnd_next});
      n_fail++;
    end
    n_cmp++;
    if ({spawn_lane, spawn_idx} !== 10'd0) begin
      $display("FAIL reset_data: got lane=%0d idx=%0d want 0 0", spawn_lane, spawn_idx);
      n_fail++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run();
    logic [2:0] rnd_seq [3];
    logic [1:0] lane_exp [3];
    int done_base;
    rnd_seq = '{3'd5, 3'd5, 3'd2};
`ifdef SPAWN_NO_REPEAT_EN
    lane_exp = '{2'd1, 2'd2, 2'd3};
`else
    lane_exp = '{2'd1, 2'd1, 2'd2};
`endif
    spawn_ready = 1'b1;
    done_base = done_cnt;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL run_busy: got %b want 1", busy);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      rnd = rnd_seq[k];
      do_ticks(3, 1'b0);
      n_cmp++;
      if ({rnd_next, spawn_valid} !== 2'b00) begin
        $display("FAIL run_early_%0d: got rnd_next/valid=%b want 00", k, {rnd_next, spawn_valid});
        n_fail++;
      end
      do_ticks(1, 1'b0);
      n_cmp++;
      if (rnd_next !== 1'b1) begin
        $display("FAIL run_draw_%0d: got rnd_next=%b want 1", k, rnd_next);
        n_fail++;
      end
      @(negedge clk);
      n_cmp++;
      if ({spawn_valid, spawn_lane, spawn_idx} !== {1'b1, lane_exp[k], 8'(k)}) begin
        $display("FAIL run_offer_%0d: got valid=%b lane=%0d idx=%0d want 1 %0d %0d",
                 k, spawn_valid, spawn_lane, spawn_idx, lane_exp[k], k);
        n_fail++;
      end
      @(negedge clk);
      if (k < 2) begin
        n_cmp++;
        if ({spawn_valid, busy, done} !== 3'b010) begin
          $display("FAIL run_wait_%0d: got valid/busy/done=%b want 010", k, {spawn_valid, busy, done});
          n_fail++;
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      $display("FAIL run_done: got %b want 1", done);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, spawn_idx} !== {2'b00, 8'd2}) begin
      $display("FAIL run_idle: got done=%b busy=%b idx=%0d want 0 0 2", done, busy, spawn_idx);
      n_fail++;
    end
    n_cmp++;
    if (done_cnt - done_base !== 1) begin
      $display("FAIL run_done_count: got %0d want 1", done_cnt - done_base);
      n_fail++;
    end
  endtask

  task automatic test_start();
    spawn_ready = 1'b1;
    rnd = 3'd3;
    start = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick = 1'b0;
    do_ticks(2, 1'b0);
    pulse_start();
    do_ticks(1, 1'b0);
    n_cmp++;
    if (rnd_next !== 1'b0) begin
      $display("FAIL start_tick_counted: got rnd_next=%b want 0", rnd_next);
      n_fail++;
    end
    do_ticks(1, 1'b0);
    n_cmp++;
    if (rnd_next !== 1'b1) begin
      $display("FAIL start_wait_reload: got rnd_next=%b want 1", rnd_next);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if ({spawn_valid, spawn_lane, spawn_idx} !== {1'b1, 2'd3, 8'd0}) begin
      $display("FAIL start_offer: got valid=%b lane=%0d idx=%0d want 1 3 0",
               spawn_valid, spawn_lane, spawn_idx);
      n_fail++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pause_stall();
    int rn_base;
    spawn_ready = 1'b0;
    rnd = 3'd6;
    rn_base = rnd_next_cnt;
    pulse_start();
    do_ticks(1, 1'b0);
    do_ticks(2, 1'b1);
    do_ticks(2, 1'b0);
    n_cmp++;
    if (rnd_next !== 1'b0) begin
      $display("FAIL pause_early: got rnd_next=%b want 0", rnd_next);
      n_fail++;
    end
    do_ticks(1, 1'b0);
    n_cmp++;
    if (rnd_next !== 1'b1) begin
      $display("FAIL pause_draw: got rnd_next=%b want 1", rnd_next);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if ({rnd_next, spawn_valid} !== 2'b01) begin
      $display("FAIL pause_offer: got rnd_next/valid=%b want 01", {rnd_next, spawn_valid});
      n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      tick = i[0];
      pause = i[1];
      @(negedge clk);
      n_cmp++;
      if ({spawn_valid, spawn_lane, spawn_idx} !== {1'b1, 2'd2, 8'd0}) begin
        $display("FAIL stall_%0d: got valid=%b lane=%0d idx=%0d want 1 2 0",
                 i, spawn_valid, spawn_lane, spawn_idx);
        n_fail++;
      end
    end
    tick = 1'b0;
    pause = 1'b0;
    spawn_ready = 1'b1;
    @(negedge clk);
    spawn_ready = 1'b0;
    n_cmp++;
    if ({spawn_valid, busy, spawn_idx} !== {2'b01, 8'd1}) begin
      $display("FAIL stall_transfer: got valid=%b busy=%b idx=%0d want 0 1 1",
               spawn_valid, busy, spawn_idx);
      n_fail++;
    end
    n_cmp++;
    if (rnd_next_cnt - rn_base !== 1) begin
      $display("FAIL pause_rnd_next_count: got %0d want 1", rnd_next_cnt - rn_base);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_offer();
    int done_base;
    done_base = done_cnt;
    rnd = 3'd1;
    do_ticks(4, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({spawn_valid, spawn_idx} !== {1'b1, 8'd1}) begin
      $display("FAIL abort_pre: got valid=%b idx=%0d want 1 1", spawn_valid, spawn_idx);
      n_fail++;
    end
    spawn_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({spawn_valid, busy, done} !== 3'b000) begin
      $display("FAIL abort_async: got valid/busy/done=%b want 000", {spawn_valid, busy, done});
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({spawn_valid, busy, spawn_idx} !== 10'd0) begin
      $display("FAIL abort_idle: got valid=%b busy=%b idx=%0d want 0 0 0",
               spawn_valid, busy, spawn_idx);
      n_fail++;
    end
    n_cmp++;
    if (done_cnt - done_base !== 0) begin
      $display("FAIL abort_done: got %0d done pulses want 0", done_cnt - done_base);
      n_fail++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    tick = 1'b0;
    rnd = 3'd1;
    spawn_ready = 1'b0;
    test_reset();
    test_run();
    test_start();
    test_pause_stall();
    test_reset_mid_offer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_spawn_scheduler.md
TILE_SPAWN_SCHEDULER -- requirements
Module: tile_spawn_scheduler

Interface
REQ-001 Parameter INTERVAL, default 8: tick pulses between consecutive spawns; legal range 1..255.
REQ-002 Parameter TILE_COUNT, default 32: tiles spawned per run; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request.
REQ-006 pause  input  1  level; freezes the interval countdown.
REQ-007 tick  input  1  single-cycle time-base pulse.
REQ-008 rnd  input  3  random value from the LFSR generator, range 1..7.
REQ-009 rnd_next  output  1  single-cycle advance request to the generator.
REQ-010 spawn_valid  output  1  a spawn is offered.
REQ-011 spawn_ready  input  1  the consumer accepts the offered spawn.
REQ-012 spawn_lane  output  2  lane 0..3 of the offered tile.
REQ-013 spawn_idx  output  8  index of the offered tile, starting at 0 for each run.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  single-cycle pulse when a run completes.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DRAW, OFFER and DONE.
REQ-017 IDLE: start SHALL load the countdown with INTERVAL, clear spawn_idx and the last-lane record, and go to WAIT; a tick in the same cycle is not counted.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 WAIT: each tick with pause=0 SHALL decrement the countdown; ticks with pause=1 SHALL be ignored.
REQ-020 WAIT: the tick that takes the countdown from 1 to 0 SHALL cause the next state to be DRAW, so the first spawn follows exactly INTERVAL unpaused ticks.
REQ-021 DRAW: lasts exactly one cycle; SHALL capture the lane from rnd per REQ-024 and REQ-029, assert rnd_next for that cycle only, and go to OFFER.
REQ-022 OFFER: spawn_valid=1; spawn_lane and spawn_idx SHALL stay stable until a cycle with spawn_valid and spawn_ready both high; pause SHALL NOT withdraw spawn_valid; ticks SHALL be ignored.
REQ-023 On a transfer with spawn_idx = TILE_COUNT-1: go to DONE; otherwise increment spawn_idx, reload the countdown with INTERVAL, and go to WAIT.
REQ-024 The base lane SHALL be rnd[1:0], so rnd values 4..7 map to lanes 0..3.
REQ-025 DONE: done=1 for one cycle, then IDLE; spawn_idx SHALL hold its final value until the next start.
REQ-026 spawn_valid SHALL be 0 in every state except OFFER.
REQ-027 There SHALL be no wrap-around of spawn_idx beyond TILE_COUNT-1.

Reset
REQ-028 While reset is high: state IDLE; countdown 0; spawn_idx 0; last-lane record invalid; rnd_next, spawn_valid, spawn_lane, busy and done all 0; reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-029 Macro SPAWN_NO_REPEAT_EN defined: if the base lane equals the last transferred lane and the record is valid, the lane SHALL be (base+1) mod 4. Each transfer updates the record.
REQ-030 Macro undefined: the lane SHALL equal the base lane, and no last-lane record SHALL be implemented.

Verification
REQ-031 Reset asserted mid-OFFER -> spawn_valid, busy and done go to 0 immediately; state IDLE; no transfer.
REQ-032 INTERVAL=4, TILE_COUNT=3, spawn_ready=1 held, rnd=5,5,2 at successive DRAWs, macro defined -> lanes 1,2,3; idx 0,1,2; done pulses once, one cycle after the third transfer.
REQ-033 Same stimulus as REQ-032 with the macro undefined -> lanes 1,1,2.
REQ-034 INTERVAL=4; pause=1 during ticks 2-3 -> DRAW entered only after 4 unpaused ticks; rnd_next is high for exactly one cycle per spawn.
REQ-035 spawn_ready held low for 10 cycles in OFFER, with ticks and pause toggling -> spawn_lane and spawn_idx stable and spawn_valid held high; transfer occurs on the first ready cycle.
REQ-036 start asserted during WAIT, and start coincident with tick in IDLE -> the first is ignored; the second starts a run with the countdown still at INTERVAL.
